// File: rtl/bpsk_pkg.sv
// Shared types and defaults for the BPSK transmit framing logic.
package bpsk_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SYNC,
    S_PAYLOAD
  } state_t;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hD391;
  localparam int          SYNC_BITS_DEF = 16;
  localparam logic        PRE_START_BIT = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bpsk_sym_timer.sv
// Symbol-period counter: flags the first and last clock of every symbol.
module bpsk_sym_timer #(
  parameter int SPS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sym_strobe,
  output logic sym_last
);

  localparam int CW = $clog2(SPS);

  logic [CW-1:0] sym_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sym_cnt_reg <= '0;
    end else if (en) begin
      sym_cnt_reg <= sym_last ? '0 : sym_cnt_reg + 1'b1;
    end
  end

  assign sym_strobe = en && (sym_cnt_reg == '0);
  assign sym_last   = en && (sym_cnt_reg == CW'(SPS - 1));

endmodule

// File: rtl/bpsk_frame_ctrl.sv
// Frame sequencer: preamble, sync word and payload serialised MSB-first
// onto the modulator bit input, with the carrier step held per frame.
module bpsk_frame_ctrl
  import bpsk_pkg::*;
#(
  parameter int                   SPS           = 16,
  parameter int                   PREAMBLE_BITS = 32,
  parameter int                   SYNC_BITS     = SYNC_BITS_DEF,
  parameter logic [SYNC_BITS-1:0] SYNC_WORD     = SYNC_WORD_DEF,
  parameter int                   LEN_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [31:0]      phase_step_cfg,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             bit_out,
  output logic [31:0]      phase_step,
  output logic             sym_strobe,
  output logic             tx_active,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int BW = $clog2(max_int(max_int(PREAMBLE_BITS, SYNC_BITS), 8));

  state_t               state_reg, state_next;
  logic [BW-1:0]        bit_cnt_reg;
  logic                 bit_reg;
  logic [SYNC_BITS-1:0] sync_sr_reg;
  logic [7:0]           shift_reg;
  logic [7:0]           hold_data_reg;
  logic                 hold_valid_reg;
  logic [LEN_W-1:0]     fetched_reg;
  logic [LEN_W-1:0]     loaded_reg;
  logic [LEN_W-1:0]     len_reg;
  logic [31:0]          phase_reg;
  logic                 done_reg;

  logic sym_last;
  logic pre_end, sync_end, byte_end;
  logic need_byte, finish;
  logic load_byte, starve, frame_end;

  bpsk_sym_timer #(
    .SPS(SPS)
  ) u_sym_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (busy),
    .clr       (!busy),
    .sym_strobe(sym_strobe),
    .sym_last  (sym_last)
  );

  assign pre_end  = (state_reg == S_PREAMBLE) && (bit_cnt_reg == BW'(PREAMBLE_BITS - 1));
  assign sync_end = (state_reg == S_SYNC)     && (bit_cnt_reg == BW'(SYNC_BITS - 1));
  assign byte_end = (state_reg == S_PAYLOAD)  && (bit_cnt_reg == BW'(7));

  // A byte boundary either needs another payload byte or closes the frame.
  assign need_byte = (sync_end && (len_reg != '0)) || (byte_end && (loaded_reg != len_reg));
  assign finish    = (sync_end && (len_reg == '0)) || (byte_end && (loaded_reg == len_reg));
  assign load_byte = sym_last && need_byte && hold_valid_reg;
  assign starve    = sym_last && need_byte && !hold_valid_reg;
  assign frame_end = sym_last && finish;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (start) state_next = S_PREAMBLE;
      S_PREAMBLE: if (sym_last && pre_end) state_next = S_SYNC;
      S_SYNC: begin
        if (frame_end || starve) state_next = S_IDLE;
        else if (load_byte)      state_next = S_PAYLOAD;
      end
      S_PAYLOAD:  if (frame_end || starve) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_reg != S_IDLE);
    tx_active  = busy;
    bit_out    = busy && bit_reg;
    phase_step = busy ? phase_reg : '0;
    byte_ready = busy && !hold_valid_reg && (fetched_reg < len_reg);
    done       = done_reg;
    underrun   = starve && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg    <= '0;
      bit_reg        <= 1'b0;
      sync_sr_reg    <= '0;
      shift_reg      <= '0;
      hold_data_reg  <= '0;
      hold_valid_reg <= 1'b0;
      fetched_reg    <= '0;
      loaded_reg     <= '0;
      len_reg        <= '0;
      phase_reg      <= '0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (byte_valid && byte_ready) begin
        hold_data_reg  <= byte_data;
        hold_valid_reg <= 1'b1;
        fetched_reg    <= fetched_reg + 1'b1;
      end
      if (state_reg == S_IDLE) begin
        if (start) begin
          len_reg        <= frame_len;
          phase_reg      <= phase_step_cfg;
          bit_reg        <= PRE_START_BIT;
          bit_cnt_reg    <= '0;
          fetched_reg    <= '0;
          loaded_reg     <= '0;
          hold_valid_reg <= 1'b0;
        end
      end else if (sym_last) begin
        if (frame_end || starve) begin
          done_reg    <= frame_end;
          bit_reg     <= 1'b0;
          bit_cnt_reg <= '0;
        end else if (load_byte) begin
          bit_reg        <= hold_data_reg[7];
          shift_reg      <= {hold_data_reg[6:0], 1'b0};
          hold_valid_reg <= 1'b0;
          loaded_reg     <= loaded_reg + 1'b1;
          bit_cnt_reg    <= '0;
        end else if (pre_end) begin
          bit_reg     <= SYNC_WORD[SYNC_BITS-1];
          sync_sr_reg <= SYNC_WORD << 1;
          bit_cnt_reg <= '0;
        end else if (state_reg == S_SYNC) begin
          bit_reg     <= sync_sr_reg[SYNC_BITS-1];
          sync_sr_reg <= sync_sr_reg << 1;
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end else if (state_reg == S_PAYLOAD) begin
          bit_reg     <= shift_reg[7];
          shift_reg   <= shift_reg << 1;
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end else begin
          // Preamble alternates every symbol.
          bit_reg     <= ~bit_reg;
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bpsk_frame_ctrl.sv
// Frame-level vectors with a bit scoreboard, plus reset corner sequences.
module tb_bpsk_frame_ctrl;

  localparam int SPS    = 4;
  localparam int PB     = 8;
  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  frame_len = '0;
  logic [31:0] phase_step_cfg = '0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, bit_out, sym_strobe, tx_active, busy, done, underrun;
  logic [31:0] phase_step;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  typedef struct {
    int          len;
    logic [31:0] data;
    logic [31:0] phase;
    int          mode;       // 0 steady source, 1 random gaps, 2 withhold after starve_at
    int          starve_at;
    int          poke;       // restart attempt and cfg change mid-frame
    int          exp_done;
    int          exp_active;
    int          exp_hs;
  } vec_t;

  vec_t vecs[5];

  bpsk_frame_ctrl #(
    .SPS(SPS),
    .PREAMBLE_BITS(PB)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .phase_step_cfg(phase_step_cfg), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .bit_out(bit_out), .phase_step(phase_step),
    .sym_strobe(sym_strobe), .tx_active(tx_active), .busy(busy),
    .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_tx_active"}, 32'(tx_active), 0);
    check({tag, "_bit_out"}, 32'(bit_out), 0);
    check({tag, "_phase_step"}, phase_step, 0);
    check({tag, "_sym_strobe"}, 32'(sym_strobe), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_underrun"}, 32'(underrun), 0);
    check({tag, "_byte_ready"}, 32'(byte_ready), 0);
  endtask

  task automatic build_model(input vec_t v);
    logic [15:0] sw;
    logic [7:0]  by;
    int          nb;
    sw = 16'hD391;
    exp_q.delete();
    for (int i = 0; i < PB; i++) exp_q.push_back(i % 2 == 0);
    for (int i = 15; i >= 0; i--) exp_q.push_back(sw[i]);
    nb = (v.mode == 2) ? v.starve_at : v.len;
    for (int b = 0; b < nb; b++) begin
      by = v.data[31-8*b -: 8];
      for (int i = 7; i >= 0; i--) exp_q.push_back(by[i]);
    end
  endtask

  task automatic run_frame(input int id, input vec_t v);
    int k, active, hs, idx, gap_run, done_cnt, done_k, urun_cnt, urun_k;
    bit ended, ready_seen, prev;
    k = 0; active = 0; hs = 0; idx = 0; gap_run = 0;
    done_cnt = 0; done_k = 0; urun_cnt = 0; urun_k = 0;
    ended = 0; ready_seen = 0; prev = 0;
    build_model(v);
    @(negedge clk);
    start = 1'b1;
    frame_len = 8'(v.len);
    phase_step_cfg = v.phase;
    byte_valid = 1'b0;
    while (!ended && k < BUDGET) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        check("first_busy", 32'(busy), 1);
        check("first_strobe", 32'(sym_strobe), 1);
        check("first_bit", 32'(bit_out), 1);
        check("first_phase", phase_step, v.phase);
      end
      if (v.poke != 0 && k == 20) begin
        start = 1'b1;
        frame_len = 8'd7;
        phase_step_cfg = ~v.phase;
      end else if (v.poke != 0 && k == 21) begin
        start = 1'b0;
      end
      if (tx_active) begin
        active++;
        check("phase_hold", phase_step, v.phase);
      end
      if (sym_strobe) begin
        check("symbols_left", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("bit_out", 32'(bit_out), 32'(exp_q.pop_front()));
      end else if (tx_active) begin
        check("bit_stable", 32'(bit_out), 32'(prev));
      end
      prev = bit_out;
      if (done) begin done_cnt++; done_k = k; end
      if (underrun) begin urun_cnt++; urun_k = k; end
      if (byte_ready) ready_seen = 1;
      // Source: present the next byte for the coming edge.
      if (idx < v.len && idx < 4) byte_data = v.data[31-8*idx -: 8];
      case (v.mode)
        1: begin
          byte_valid = (idx < v.len) && (($urandom_range(0, 1) == 1) || gap_run >= 5);
          gap_run = byte_valid ? 0 : gap_run + 1;
        end
        2: byte_valid = (idx < v.starve_at);
        default: byte_valid = (idx < v.len);
      endcase
      if (byte_valid && byte_ready) begin
        hs++;
        idx++;
      end
      if (!busy && k > 1) ended = 1;
    end
    byte_valid = 1'b0;
    check("frame_ended", 32'(ended), 1);
    check("done_count", done_cnt, v.exp_done);
    check("underrun_count", urun_cnt, 1 - v.exp_done);
    if (v.exp_done != 0) check("done_cycle", done_k, v.exp_active + 1);
    else check("underrun_cycle", urun_k, v.exp_active);
    check("active_cycles", active, v.exp_active);
    check("handshakes", hs, v.exp_hs);
    check("bits_remaining", exp_q.size(), 0);
    if (v.len == 0) check("ready_never", 32'(ready_seen), 0);
    @(negedge clk);
    check("idle_after_busy", 32'(busy), 0);
    check("idle_after_done", 32'(done), 0);
    $display("frame %0d len=%0d mode=%0d active=%0d handshakes=%0d done=%0d underrun=%0d",
             id, v.len, v.mode, active, hs, done_cnt, urun_cnt);
  endtask

  initial begin
    vecs[0] = '{len:2, data:32'hA53C_0000, phase:32'h1234_5678, mode:0, starve_at:0, poke:0,
                exp_done:1, exp_active:160, exp_hs:2};
    vecs[1] = '{len:0, data:32'h0000_0000, phase:32'hDEAD_BEEF, mode:0, starve_at:0, poke:0,
                exp_done:1, exp_active:96, exp_hs:0};
    vecs[2] = '{len:3, data:32'hA53C_9600, phase:32'h0000_1000, mode:2, starve_at:2, poke:0,
                exp_done:0, exp_active:160, exp_hs:2};
    vecs[3] = '{len:3, data:32'hA53C_9600, phase:32'h8000_0001, mode:1, starve_at:0, poke:0,
                exp_done:1, exp_active:192, exp_hs:3};
    vecs[4] = '{len:1, data:32'hFF00_0000, phase:32'h0F0F_0F0F, mode:0, starve_at:0, poke:1,
                exp_done:1, exp_active:128, exp_hs:1};

    repeat (3) @(negedge clk);
    check_idle("reset");

    // start coinciding with reset must be ignored
    start = 1'b1;
    phase_step_cfg = 32'h5555_AAAA;
    frame_len = 8'd1;
    @(negedge clk);
    check_idle("start_in_rst");
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("no_frame_after_rst_start", 32'(busy), 0);
    $display("reset sequence done");

    for (int i = 0; i < 5; i++) run_frame(i, vecs[i]);

    // Reset in the middle of SYNC, with a byte already prefetched.
    @(negedge clk);
    start = 1'b1;
    frame_len = 8'd2;
    phase_step_cfg = 32'h7777_0001;
    byte_data = 8'h11;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      byte_valid = 1'b1;
    end
    check("mid_busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    check_idle("mid_rst");
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", 32'(done), 0);
      check("post_rst_busy", 32'(busy), 0);
    end
    $display("mid-frame reset sequence done");
    run_frame(5, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bpsk_frame_ctrl.md
# bpsk_frame_ctrl

Frame sequencer for the BPSK transmit path. It accepts a frame request and payload bytes over a valid/ready stream and serialises preamble, sync word and payload MSB-first onto the modulator's `bit_in`, one bit per symbol period. It also latches and holds the carrier `phase_step` for the frame duration. It sits between the packet/byte source and the BPSK transmitter, and is the only driver of that transmitter's `bit_in` and `phase_step`.

## Interface
- `SPS`, 16: samples (clk cycles) per symbol; must be ≥ 2.
- `PREAMBLE_BITS`, 32: preamble length in symbols; pattern is 1,0,1,0,… starting with 1.
- `SYNC_WORD`, 16'hD391: sync word, sent MSB-first.
- `SYNC_BITS`, 16: sync word width.
- `LEN_W`, 8: width of the frame length in bytes.

- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: frame request; sampled only in IDLE.
- `frame_len` in LEN_W: payload bytes, latched with `start`; 0 is legal.
- `phase_step_cfg` in 32: carrier step, latched with `start`.
- `byte_data` in 8: payload byte.
- `byte_valid` in 1: `byte_data` is valid.
- `byte_ready` out 1: controller accepts a byte this cycle.
- `bit_out` out 1: symbol bit to the modulator `bit_in`.
- `phase_step` out 32: to the transmitter phase accumulator.
- `sym_strobe` out 1: high on the first cycle of every transmitted symbol.
- `tx_active` out 1: a frame symbol is on `bit_out`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse on normal frame completion.
- `underrun` out 1: one-cycle pulse on payload starvation abort.

## Operation
- **Reset values:** state IDLE, all outputs 0, including `phase_step`. The holding register, counters and latched length are cleared.
- **FSM states:** IDLE → PREAMBLE → SYNC → PAYLOAD → IDLE.
  - IDLE & `start`: latch `frame_len` and `phase_step_cfg`, then go to PREAMBLE.
  - PREAMBLE goes to SYNC after `PREAMBLE_BITS` symbols.
  - SYNC goes to PAYLOAD after `SYNC_BITS` symbols. If the latched length is 0, SYNC instead goes to IDLE with `done`.
  - PAYLOAD goes to IDLE with `done` after `8*frame_len` symbols.
- **Symbol timer:** `sym_cnt` counts 0..SPS-1 and wraps while `busy`.
  - The next bit is loaded when `sym_cnt` wraps.
  - `sym_strobe` = `busy && sym_cnt==0`.
- **Byte path:** a one-byte holding register with a valid flag, feeding an 8-bit shift register.
  - `byte_ready` = `busy && !hold_valid && fetched < frame_len`.
  - A transfer occurs on a cycle where `byte_valid && byte_ready`.
  - Prefetch is allowed from the first PREAMBLE cycle onward.
- **Starvation:** a byte boundary is the last cycle of the final SYNC symbol or of bit 7 of a payload byte. If a further payload byte is required there and `hold_valid` = 0:
  - pulse `underrun`;
  - go to IDLE;
  - drive `tx_active`, `bit_out` and `phase_step` to 0;
  - do not pulse `done`.
- **`phase_step`:** constant for the whole frame; returns to 0 in IDLE.
- `start` while `busy` is ignored. `start` in the same cycle as `rst` is ignored.
- **`rst` mid-frame:** all outputs return to reset values on the next edge. Any held byte is discarded, and no `done` or `underrun` pulse is produced.
- Counters are width-sized to their maximum terminal count; no wrap-around is possible within a frame.

## Timing
- Let T be the cycle in which `start` is accepted.
- At T+1: `busy`, `tx_active` and `sym_strobe` = 1, `bit_out` = 1 (first preamble bit), and `phase_step` = the latched value.
- Each bit is held for exactly SPS cycles; `bit_out` changes only in `sym_strobe` cycles.
- Active length N = SPS·(PREAMBLE_BITS + SYNC_BITS + 8·frame_len) cycles, spanning T+1..T+N.
- At T+N+1: `done` = 1 for one cycle, and `busy`, `tx_active` and `bit_out` = 0.
- A new `start` is accepted at T+N+1 or later. There are no back-to-back frames without one IDLE cycle.
- `byte_ready` is combinational from registered state only; it has no dependence on `byte_valid`.
- The transmitter's CORDIC latency is downstream and is not compensated here.

## Structure
- Shared package `bpsk_pkg` holds:
  - the state enum (IDLE, PREAMBLE, SYNC, PAYLOAD);
  - default `SYNC_WORD` and `SYNC_BITS`;
  - the preamble start-bit constant.
- Sub-module `bpsk_sym_timer`: SPS counter with enable and synchronous clear. It outputs `sym_strobe` and `sym_last` (`sym_cnt==SPS-1`).
- All remaining logic (FSM, bit counter, holding/shift registers) lives in `bpsk_frame_ctrl`.

## Test plan
- **Normal frame.** Setup: SPS=4, PREAMBLE_BITS=8, frame_len=2, bytes 0xA5, 0x3C, source always valid. Required response:
  - `bit_out` per symbol = 10101010, 1101001110010001, 10100101, 00111100;
  - `tx_active` high for exactly 160 cycles;
  - `done` at T+161.
- **Zero-length frame.** Setup: frame_len=0. Required response: preamble and sync only, `done` after SPS·24 cycles, `byte_ready` never asserted.
- **Starvation.** Setup: frame_len=3, source withholds the third byte. Required response: `underrun` pulses at the end of bit 7 of byte 2, next cycle `busy` = 0, no `done`.
- **Mid-frame reset.** Setup: `rst` asserted during SYNC. Required response:
  - next cycle all outputs 0 and `phase_step` = 0;
  - a following `start` yields a clean frame from the first preamble bit.
- **Ignored start and phase hold.** Setup: pulse `start` while `busy` and change `phase_step_cfg` mid-frame. Required response: the frame is unaffected, `phase_step` keeps the value latched at T, and a new frame starts only after IDLE.
- **Source back-pressure.** Setup: random `byte_valid` gaps, each shorter than one byte time. Required response: the payload bitstream is identical to the gap-free case, and exactly `frame_len` handshakes occur.
